slave_reg_responder: RTL and testbench



---
 rtl/slave_reg_pkg.sv | 32 +++
 rtl/slave_reg_job_fsm.sv | 95 +++++++++
 rtl/slave_reg_responder.sv | 158 +++++++++++++++
 tb/tb_slave_reg_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/slave_reg_pkg.sv
// slave_reg_pkg
// Shared constants for the slave-bus register responder: dword addresses of
// the register map, bit positions inside CTRL and STATUS, and the job FSM
// state encoding. There are no ports because this file is a package.
// Optional feature macro: SLAVE_REG_ABORT_EN (CTRL.ABORT / STATUS.ABORTED).
package slave_reg_pkg;

  // Register map, decoded from the low four address bits only
  localparam logic [3:0] ADDR_ID           = 4'h0;
  localparam logic [3:0] ADDR_CTRL         = 4'h1;
  localparam logic [3:0] ADDR_STATUS       = 4'h2;
  localparam logic [3:0] ADDR_LENGTH       = 4'h3;
  localparam logic [3:0] ADDR_COUNT        = 4'h4;
  localparam logic [3:0] ADDR_SCRATCH_BASE = 4'h8;

  // CTRL bits
  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_INTR_EN_BIT = 1;
  localparam int CTRL_ABORT_BIT   = 2;

  // STATUS bits
  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_ABORTED_BIT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } job_state_t;

endpackage

// File: rtl/slave_reg_job_fsm.sv
// slave_reg_job_fsm
// Job counter FSM (IDLE -> RUN -> FIN -> IDLE). A start in IDLE latches the
// job length and clears the counter; RUN counts one per cycle until the
// counter reaches the latched length; FIN lasts one cycle and pulses done.
// An abort in RUN returns to IDLE with the counter frozen.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   start request (single-cycle)
//   abort       in   abort request (single-cycle)
//   length      in   job length, sampled when the job starts
//   busy        out  high whenever the FSM is not IDLE
//   count       out  job progress counter
//   done_pulse  out  high during the FIN cycle
//   abort_pulse out  high in the RUN cycle that accepts an abort
module slave_reg_job_fsm
  import slave_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] length,
  output logic        busy,
  output logic [31:0] count,
  output logic        done_pulse,
  output logic        abort_pulse
);

  job_state_t  state;
  job_state_t  state_next;
  logic [31:0] len_latch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The end compare uses len_latch so LENGTH writes during a job are harmless.
  // Every accepted start clears the counter, including zero-length jobs.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      len_latch <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count     <= '0;
            len_latch <= length;
          end
        end
        RUN: begin
          if (!abort) begin
            count <= count + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Leaving RUN when count == len-1 means count has become len by FIN.
  always_comb begin
    state_next  = state;
    done_pulse  = 1'b0;
    abort_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (length == 32'd0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next  = IDLE;
          abort_pulse = 1'b1;
        end else if (count == len_latch - 32'd1) begin
          state_next = FIN;
        end
      end
      FIN: begin
        done_pulse = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/slave_reg_responder.sv
// slave_reg_responder
// Slave-bus register responder: decodes writes and reads from the slave BFM,
// holds ID/CTRL/STATUS/LENGTH/COUNT registers plus a small scratch RAM, and
// runs the job counter FSM. Reads have one cycle of latency and S_RDATA holds
// until the next read. Only address bits [3:0] are decoded, so the map aliases.
// Optional feature macro: SLAVE_REG_ABORT_EN adds CTRL.ABORT and
// STATUS.ABORTED; without it those bits read 0 and writes to them are ignored.
// Ports:
//   CLK      in   system clock, rising edge
//   RST      in   synchronous active-high reset
//   S_WE     in   write strobe
//   S_WADDR  in   write dword address
//   S_WDATA  in   write data
//   S_RE     in   read strobe
//   S_RADDR  in   read dword address
//   S_RDATA  out  registered read data
//   BUSY     out  job running
//   INTR     out  level interrupt
module slave_reg_responder
  import slave_reg_pkg::*;
#(
  parameter int          C_ADDR_BITS     = 16,
  parameter logic [31:0] C_ID            = 32'h5352_0001,
  parameter int          C_SCRATCH_DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   S_WE,
  input  logic [C_ADDR_BITS-1:0] S_WADDR,
  input  logic [31:0]            S_WDATA,
  input  logic                   S_RE,
  input  logic [C_ADDR_BITS-1:0] S_RADDR,
  output logic [31:0]            S_RDATA,
  output logic                   BUSY,
  output logic                   INTR
);

  localparam int SCR_BITS = (C_SCRATCH_DEPTH > 1) ? $clog2(C_SCRATCH_DEPTH) : 1;

  logic [3:0]          wr_addr;
  logic [3:0]          rd_addr;
  logic [SCR_BITS-1:0] wr_idx;
  logic [SCR_BITS-1:0] rd_idx;
  logic                ctrl_wr;
  logic                start_req;
  logic                abort_req;
  logic                ctrl_intr_en;
  logic                status_done;
  logic                status_aborted;
  logic [31:0]         length_reg;
  logic [31:0]         scratch [C_SCRATCH_DEPTH];
  logic [31:0]         rd_value;
  logic [31:0]         job_count;
  logic                job_busy;
  logic                fsm_done_pulse;
  logic                fsm_abort_pulse;
  logic                unused_bits;

  assign wr_addr = S_WADDR[3:0];
  assign rd_addr = S_RADDR[3:0];
  assign wr_idx  = S_WADDR[SCR_BITS-1:0];
  assign rd_idx  = S_RADDR[SCR_BITS-1:0];
  assign ctrl_wr = S_WE && (wr_addr == ADDR_CTRL);

`ifdef SLAVE_REG_ABORT_EN
  assign abort_req = ctrl_wr && S_WDATA[CTRL_ABORT_BIT];

  // ABORTED is sticky until cleared by W1C; a new abort wins over the clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      status_aborted <= 1'b0;
    end else if (fsm_abort_pulse) begin
      status_aborted <= 1'b1;
    end else if (S_WE && (wr_addr == ADDR_STATUS) && S_WDATA[STAT_ABORTED_BIT]) begin
      status_aborted <= 1'b0;
    end
  end

  assign unused_bits = ^{S_WADDR[C_ADDR_BITS-1:4], S_RADDR[C_ADDR_BITS-1:4]};
`else
  assign abort_req      = 1'b0;
  assign status_aborted = 1'b0;
  assign unused_bits    = ^{S_WADDR[C_ADDR_BITS-1:4], S_RADDR[C_ADDR_BITS-1:4],
                            fsm_abort_pulse};
`endif

  // An abort in the same CTRL write suppresses the start
  assign start_req = ctrl_wr && S_WDATA[CTRL_START_BIT] && !abort_req;

  slave_reg_job_fsm u_job_fsm (
    .clk         (CLK),
    .rst         (RST),
    .start       (start_req),
    .abort       (abort_req),
    .length      (length_reg),
    .busy        (job_busy),
    .count       (job_count),
    .done_pulse  (fsm_done_pulse),
    .abort_pulse (fsm_abort_pulse)
  );

  // Writable state. DONE set from the FSM beats a same-cycle W1C clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ctrl_intr_en <= 1'b0;
      status_done  <= 1'b0;
      length_reg   <= '0;
      for (int i = 0; i < C_SCRATCH_DEPTH; i++) begin
        scratch[i] <= '0;
      end
    end else begin
      if (ctrl_wr) begin
        ctrl_intr_en <= S_WDATA[CTRL_INTR_EN_BIT];
      end
      if (fsm_done_pulse) begin
        status_done <= 1'b1;
      end else if (S_WE && (wr_addr == ADDR_STATUS) && S_WDATA[STAT_DONE_BIT]) begin
        status_done <= 1'b0;
      end
      if (S_WE && (wr_addr == ADDR_LENGTH)) begin
        length_reg <= S_WDATA;
      end
      if (S_WE && wr_addr[3]) begin
        scratch[wr_idx] <= S_WDATA;
      end
    end
  end

  // Read mux sees pre-edge register values, so a same-address write
  // colliding with a read returns the old contents.
  always_comb begin
    rd_value = '0;
    if (rd_addr[3]) begin
      rd_value = scratch[rd_idx];
    end else begin
      case (rd_addr)
        ADDR_ID:     rd_value = C_ID;
        ADDR_CTRL:   rd_value = {30'd0, ctrl_intr_en, 1'b0};
        ADDR_STATUS: rd_value = {29'd0, status_aborted, status_done, job_busy};
        ADDR_LENGTH: rd_value = length_reg;
        ADDR_COUNT:  rd_value = job_count;
        default:     rd_value = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      S_RDATA <= '0;
    end else if (S_RE) begin
      S_RDATA <= rd_value;
    end
  end

  assign BUSY = job_busy;
  assign INTR = ctrl_intr_en & (status_done | status_aborted);

endmodule

// File: tb/tb_slave_reg_responder.sv
// tb_slave_reg_responder
// Directed bench for slave_reg_responder: register map, aliasing, scratch,
// read latency/hold, read/write collision, job FSM timing, reset mid-job and,
// with SLAVE_REG_ABORT_EN defined, the abort path.
module tb_slave_reg_responder;

  logic        CLK;
  logic        RST;
  logic        S_WE;
  logic [15:0] S_WADDR;
  logic [31:0] S_WDATA;
  logic        S_RE;
  logic [15:0] S_RADDR;
  logic [31:0] S_RDATA;
  logic        BUSY;
  logic        INTR;

  int checkCount;
  int passCount;

  slave_reg_responder dut (
    .CLK     (CLK),
    .RST     (RST),
    .S_WE    (S_WE),
    .S_WADDR (S_WADDR),
    .S_WDATA (S_WDATA),
    .S_RE    (S_RE),
    .S_RADDR (S_RADDR),
    .S_RDATA (S_RDATA),
    .BUSY    (BUSY),
    .INTR    (INTR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drive one bus cycle, let the edge take it, then release the strobes
  task automatic applyStimulus(input logic we, input logic [15:0] waddr,
                               input logic [31:0] wdata, input logic re,
                               input logic [15:0] raddr);
    S_WE    = we;
    S_WADDR = waddr;
    S_WDATA = wdata;
    S_RE    = re;
    S_RADDR = raddr;
    @(posedge CLK);
    #1;
    S_WE = 1'b0;
    S_RE = 1'b0;
  endtask

  task automatic writeReg(input logic [15:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, data, 1'b0, 16'h0);
  endtask

  task automatic readCheck(input string tag, input logic [15:0] addr,
                           input logic [31:0] expected);
    applyStimulus(1'b0, 16'h0, 32'h0, 1'b1, addr);
    checkOutput(tag, S_RDATA, expected);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Counts the cycles BUSY stays high, starting with the current cycle
  task automatic measureBusy(output int n);
    n = 0;
    while (BUSY === 1'b1 && n < 200) begin
      n++;
      @(posedge CLK);
      #1;
    end
  endtask

  int busyCycles;

  initial begin
    checkCount = 0;
    passCount  = 0;
    RST     = 1'b1;
    S_WE    = 1'b0;
    S_WADDR = '0;
    S_WDATA = '0;
    S_RE    = 1'b0;
    S_RADDR = '0;
    idleCycles(2);
    RST = 1'b0;

    $display("[TB] reset state and ID");
    checkOutput("rst_rdata", S_RDATA, 32'h0);
    checkOutput("rst_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("rst_intr", {31'd0, INTR}, 32'd0);
    readCheck("id", 16'h0000, 32'h5352_0001);
    readCheck("status_rst", 16'h0002, 32'h0);
    readCheck("id_alias", 16'h0010, 32'h5352_0001);
    idleCycles(2);
    checkOutput("rdata_hold", S_RDATA, 32'h5352_0001);

    $display("[TB] scratch and holes");
    for (int i = 10; i < 16; i++) begin
      writeReg(16'(i), 32'h100 + 32'(i));
    end
    readCheck("scratch_alias_1a", 16'h001A, 32'h0000_010A);
    readCheck("scratch_alias_2f", 16'h002F, 32'h0000_010F);
    readCheck("scratch_8_untouched", 16'h0008, 32'h0);
    writeReg(16'h0005, 32'hDEAD_BEEF);
    readCheck("hole_5", 16'h0005, 32'h0);
    writeReg(16'h0000, 32'h1234_5678);
    readCheck("id_ro", 16'h0000, 32'h5352_0001);

    $display("[TB] job of length 5");
    writeReg(16'h0003, 32'd5);
    writeReg(16'h0001, 32'h3);
    checkOutput("busy_after_start", {31'd0, BUSY}, 32'd1);
    measureBusy(busyCycles);
    checkOutput("busy_len5", 32'(busyCycles), 32'd6);
    readCheck("count_len5", 16'h0004, 32'd5);
    readCheck("status_done", 16'h0002, 32'h2);
    readCheck("ctrl_read", 16'h0001, 32'h2);
    checkOutput("intr_set", {31'd0, INTR}, 32'd1);
    writeReg(16'h0002, 32'h2);
    checkOutput("intr_clr", {31'd0, INTR}, 32'd0);
    readCheck("status_clr", 16'h0002, 32'h0);

    $display("[TB] zero-length job");
    writeReg(16'h0003, 32'd0);
    writeReg(16'h0001, 32'h3);
    measureBusy(busyCycles);
    checkOutput("busy_len0", 32'(busyCycles), 32'd1);
    readCheck("status_len0", 16'h0002, 32'h2);
    readCheck("count_len0", 16'h0004, 32'd0);
    writeReg(16'h0002, 32'h2);

    $display("[TB] start and length write during run");
    writeReg(16'h0003, 32'd4);
    writeReg(16'h0001, 32'h3);
    writeReg(16'h0003, 32'd20);
    writeReg(16'h0001, 32'h3);
    measureBusy(busyCycles);
    checkOutput("busy_rest_len4", 32'(busyCycles), 32'd3);
    readCheck("count_len4", 16'h0004, 32'd4);
    writeReg(16'h0002, 32'h2);
    idleCycles(5);
    readCheck("no_second_done", 16'h0002, 32'h0);
    checkOutput("busy_idle", {31'd0, BUSY}, 32'd0);

    $display("[TB] read/write collision");
    applyStimulus(1'b1, 16'h0003, 32'd7, 1'b1, 16'h0003);
    checkOutput("collide_old", S_RDATA, 32'd20);
    readCheck("collide_new", 16'h0003, 32'd7);

    $display("[TB] reset mid-job");
    writeReg(16'h0003, 32'd10);
    writeReg(16'h0001, 32'h3);
    idleCycles(2);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    checkOutput("rstjob_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("rstjob_intr", {31'd0, INTR}, 32'd0);
    checkOutput("rstjob_rdata", S_RDATA, 32'h0);
    readCheck("rstjob_status", 16'h0002, 32'h0);
    readCheck("rstjob_count", 16'h0004, 32'h0);
    readCheck("rstjob_length", 16'h0003, 32'h0);
    readCheck("rstjob_scratch", 16'h000A, 32'h0);
    idleCycles(12);
    readCheck("rstjob_no_done", 16'h0002, 32'h0);

`ifdef SLAVE_REG_ABORT_EN
    $display("[TB] abort");
    writeReg(16'h0003, 32'd100);
    writeReg(16'h0001, 32'h3);
    idleCycles(9);
    writeReg(16'h0001, 32'h6);
    checkOutput("abort_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("abort_intr", {31'd0, INTR}, 32'd1);
    readCheck("abort_status", 16'h0002, 32'h4);
    readCheck("abort_count", 16'h0004, 32'd9);
    idleCycles(3);
    readCheck("abort_count_frozen", 16'h0004, 32'd9);
    writeReg(16'h0002, 32'h4);
    checkOutput("abort_intr_clr", {31'd0, INTR}, 32'd0);
    writeReg(16'h0001, 32'h7);
    checkOutput("abort_beats_start", {31'd0, BUSY}, 32'd0);
    readCheck("abort_idle_status", 16'h0002, 32'h0);
`else
    $display("[TB] abort bits inert");
    writeReg(16'h0003, 32'd3);
    writeReg(16'h0001, 32'h7);
    checkOutput("noabort_busy", {31'd0, BUSY}, 32'd1);
    measureBusy(busyCycles);
    checkOutput("noabort_len3", 32'(busyCycles), 32'd4);
    readCheck("noabort_status", 16'h0002, 32'h2);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
